// File: rtl/bit_stream_monitor.sv
// +----------------------------------------------------------------------------
// | Module   : bit_stream_monitor
// | Function : Serial monitor; detects overlapping 1011 sequences and tracks
// |            parity, a saturating ones count and a wrapping detection count.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module bit_stream_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             det,
  output logic             parity,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] det_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_1    = 2'b01,
    S_10   = 2'b10,
    S_101  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] c_ones_max = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_hit;
  logic             r_det;
  logic             r_parity;
  logic [CNT_W-1:0] r_ones_cnt;
  logic [CNT_W-1:0] r_det_cnt;

  // Transition assumes the bit is consumed; the register stage applies the
  // bit_valid gating.
  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = bit_in ? S_1 : S_IDLE;
      S_1:    w_state_nxt = bit_in ? S_1 : S_10;
      S_10:   w_state_nxt = bit_in ? S_101 : S_IDLE;
      S_101: begin
        w_state_nxt = bit_in ? S_1 : S_10;
        w_hit       = bit_in;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state    <= S_IDLE;
      r_det      <= 1'b0;
      r_parity   <= 1'b0;
      r_ones_cnt <= '0;
      r_det_cnt  <= '0;
    end else begin
      r_det <= bit_valid && w_hit;
      if (bit_valid) begin
        r_state  <= w_state_nxt;
        r_parity <= r_parity ^ bit_in;
        if (bit_in && (r_ones_cnt != c_ones_max)) begin
          r_ones_cnt <= r_ones_cnt + 1'b1;
        end
        if (w_hit) begin
          r_det_cnt <= r_det_cnt + 1'b1;
        end
      end
    end
  end

  assign det      = r_det;
  assign parity   = r_parity;
  assign ones_cnt = r_ones_cnt;
  assign det_cnt  = r_det_cnt;
  assign state    = r_state;

endmodule

`default_nettype wire
